// File: rtl/reg_timer_pkg.sv
// Shared field widths, moduli, mode encodings and state enum
// for the reg_timekeeper time-of-day block.
package reg_timer_pkg;

  localparam int FIELD_W = 6;
  localparam int SEC_MAX = 60;
  localparam int MIN_MAX = 60;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_SET_T = 2'b01;
  localparam logic [1:0] MODE_SET_A = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_T = 2'd1,
    ST_SET_A = 2'd2
  } state_e;

  typedef logic [FIELD_W-1:0] field_t;

  function automatic field_t wrap_inc(
    input field_t      v,
    input int unsigned max
  );
    if (v == field_t'(max - 1)) begin
      return '0;
    end
    return v + field_t'(1);
  endfunction

endpackage

// File: rtl/reg_timekeeper_prescaler.sv
// Seconds prescaler: free-running modulo-TICK_DIV counter with
// restart input; tick is registered and high while count is last.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;
  logic          tick_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || cnt_q == LAST) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/reg_timekeeper.sv
// HH:MM:SS timekeeper with set modes and optional alarm.
// Alarm logic present only when REG_TIMEKEEPER_ALARM_EN is defined.
module reg_timekeeper
  import reg_timer_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int HOUR_MAX  = 24,
  parameter int ALARM_LEN = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               minute_set,
  input  logic               hour_set,
  input  logic               alarm_on,
  input  logic               alarm_ack,
  output logic               second_tick,
  output logic               day_tick,
  output logic [FIELD_W-1:0] second_data,
  output logic [FIELD_W-1:0] minute_data,
  output logic [FIELD_W-1:0] hour_data,
  output logic               alarm_active
);

  localparam field_t RING_LAST = FIELD_W'(ALARM_LEN - 1);

  state_e state_q;
  state_e state_d;

  logic   tick;
  logic   enter_t;
  logic   leave_t;
  logic   pre_clear;
  logic   run_tick;
  logic   set_t_tick;

  field_t sec_q;
  field_t sec_d;
  field_t min_q;
  field_t min_d;
  field_t hour_q;
  field_t hour_d;
  logic   day_q;
  logic   day_d;

  logic   sec_wrap;
  logic   min_wrap;
  logic   hour_wrap;

  always_comb begin
    state_d = ST_RUN;
    case (mode)
      MODE_SET_T: state_d = ST_SET_T;
`ifdef REG_TIMEKEEPER_ALARM_EN
      MODE_SET_A: state_d = ST_SET_A;
`endif
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign enter_t = (state_d == ST_SET_T) &&
                   (state_q != ST_SET_T);
  assign leave_t = (state_q == ST_SET_T) &&
                   (state_d != ST_SET_T);

  // Restart on both edges of set-time so run resumes a full second.
  assign pre_clear = enter_t | leave_t;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (pre_clear),
    .tick  (tick)
  );

  assign set_t_tick = tick && (state_q == ST_SET_T);
  assign run_tick   = tick && !enter_t &&
                      (state_q != ST_SET_T);

  assign sec_wrap  = (sec_q == field_t'(SEC_MAX - 1));
  assign min_wrap  = (min_q == field_t'(MIN_MAX - 1));
  assign hour_wrap = (hour_q == field_t'(HOUR_MAX - 1));

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    day_d  = 1'b0;
    if (enter_t) begin
      sec_d = '0;
    end else if (set_t_tick) begin
      if (minute_set) begin
        min_d = wrap_inc(min_q, MIN_MAX);
      end
      if (hour_set) begin
        hour_d = wrap_inc(hour_q, HOUR_MAX);
      end
    end else if (run_tick) begin
      sec_d = wrap_inc(sec_q, SEC_MAX);
      if (sec_wrap) begin
        min_d = wrap_inc(min_q, MIN_MAX);
        if (min_wrap) begin
          hour_d = wrap_inc(hour_q, HOUR_MAX);
          day_d  = hour_wrap;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      day_q  <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      day_q  <= day_d;
    end
  end

  assign second_tick = tick;
  assign day_tick    = day_q;
  assign second_data = sec_q;

`ifdef REG_TIMEKEEPER_ALARM_EN
  field_t amin_q;
  field_t amin_d;
  field_t ahour_q;
  field_t ahour_d;
  field_t ring_q;
  field_t ring_d;
  logic   act_q;
  logic   act_d;
  logic   match;

  always_comb begin
    amin_d  = amin_q;
    ahour_d = ahour_q;
    if (tick && state_q == ST_SET_A) begin
      if (minute_set) begin
        amin_d = wrap_inc(amin_q, MIN_MAX);
      end
      if (hour_set) begin
        ahour_d = wrap_inc(ahour_q, HOUR_MAX);
      end
    end
  end

  // Match on the tick that rolls seconds over into the alarm minute.
  assign match = run_tick && alarm_on && sec_wrap &&
                 (min_d == amin_q) && (hour_d == ahour_q);

  always_comb begin
    act_d  = act_q;
    ring_d = ring_q;
    if (match) begin
      act_d  = 1'b1;
      ring_d = '0;
    end else if (act_q) begin
      if (alarm_ack || !alarm_on) begin
        act_d = 1'b0;
      end else if (tick) begin
        if (ring_q == RING_LAST) begin
          act_d = 1'b0;
        end else begin
          ring_d = ring_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      amin_q  <= '0;
      ahour_q <= '0;
      ring_q  <= '0;
      act_q   <= 1'b0;
    end else begin
      amin_q  <= amin_d;
      ahour_q <= ahour_d;
      ring_q  <= ring_d;
      act_q   <= act_d;
    end
  end

  assign minute_data  = (state_q == ST_SET_A) ? amin_q : min_q;
  assign hour_data    = (state_q == ST_SET_A) ? ahour_q : hour_q;
  assign alarm_active = act_q;
`else
  logic unused_alarm;

  assign unused_alarm = alarm_on ^ alarm_ack ^ (^RING_LAST);
  assign minute_data  = min_q;
  assign hour_data    = hour_q;
  assign alarm_active = 1'b0;
`endif

endmodule

// File: tb/tb_reg_timekeeper.sv
// Bench for reg_timekeeper: seconds-of-day reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_reg_timekeeper;

  localparam int TD  = 4;
  localparam int HM  = 24;
  localparam int AL  = 3;
  localparam int DAY = HM * 3600;

`ifdef REG_TIMEKEEPER_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       minute_set = 1'b0;
  logic       hour_set = 1'b0;
  logic       alarm_on = 1'b0;
  logic       alarm_ack = 1'b0;
  logic       second_tick;
  logic       day_tick;
  logic [5:0] second_data;
  logic [5:0] minute_data;
  logic [5:0] hour_data;
  logic       alarm_active;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  reg_timekeeper #(
    .TICK_DIV  (TD),
    .HOUR_MAX  (HM),
    .ALARM_LEN (AL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .minute_set   (minute_set),
    .hour_set     (hour_set),
    .alarm_on     (alarm_on),
    .alarm_ack    (alarm_ack),
    .second_tick  (second_tick),
    .day_tick     (day_tick),
    .second_data  (second_data),
    .minute_data  (minute_data),
    .hour_data    (hour_data),
    .alarm_active (alarm_active)
  );

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t",
               n, act, exp, $time);
    end
  endtask

  // Reference: time kept as seconds-of-day, phase as cycles into second.
  bit mv = 1'b0;
  int ph, t, am, ah, ring, st;
  bit act, dayt;

  always @(posedge clock) begin : model
    int nst, tn, m, h;
    bit tk, ent, lev, mt;
    if (reset) begin
      mv = 1'b1; ph = 0; t = 0; am = 0; ah = 0;
      act = 1'b0; ring = 0; st = 0; dayt = 1'b0;
    end else if (mv) begin
      tk  = (ph == TD - 1);
      nst = 0;
      if (mode == 2'b01) nst = 1;
      if (mode == 2'b10 && ALARM) nst = 2;
      ent = (nst == 1) && (st != 1);
      lev = (st == 1) && (nst != 1);
      ph  = (ent || lev) ? 0 : (ph + 1) % TD;
      dayt = 1'b0;
      mt = 1'b0;
      if (ent) begin
        t = t - t % 60;
      end else if (tk && st == 1) begin
        h = t / 3600;
        m = (t / 60) % 60;
        if (minute_set) m = (m + 1) % 60;
        if (hour_set) h = (h + 1) % HM;
        t = h * 3600 + m * 60;
      end else if (tk) begin
        tn = (t + 1) % DAY;
        dayt = (tn == 0);
        mt = ALARM && alarm_on && (t % 60 == 59) &&
             (tn / 60 == ah * 60 + am);
        t = tn;
      end
      if (tk && st == 2) begin
        if (minute_set) am = (am + 1) % 60;
        if (hour_set) ah = (ah + 1) % HM;
      end
      if (mt) begin
        act = 1'b1;
        ring = 0;
      end else if (act) begin
        if (alarm_ack || !alarm_on) begin
          act = 1'b0;
        end else if (tk) begin
          ring++;
          if (ring == AL) act = 1'b0;
        end
      end
      st = nst;
    end
  end

  always @(negedge clock) begin
    if (mv) begin
      chk("second_tick", 32'(second_tick), 32'(ph == TD - 1));
      chk("day_tick", 32'(day_tick), 32'(dayt));
      chk("second_data", 32'(second_data), 32'(t % 60));
      chk("minute_data", 32'(minute_data),
          32'((st == 2) ? am : (t / 60) % 60));
      chk("hour_data", 32'(hour_data),
          32'((st == 2) ? ah : t / 3600));
      chk("alarm_active", 32'(alarm_active), 32'(act));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic hms(input string n, input int h,
                     input int m, input int s);
    chk({n, "_hour"}, 32'(hour_data), 32'(h));
    chk({n, "_min"}, 32'(minute_data), 32'(m));
    chk({n, "_sec"}, 32'(second_data), 32'(s));
  endtask

  initial begin : stim
    int nt;
    cyc(5);
    reset = 1'b0;
    hms("reset", 0, 0, 0);
    chk("reset_tick", 32'(second_tick), 0);
    chk("reset_alarm", 32'(alarm_active), 0);

    nt = 0;
    repeat (240) begin
      cyc(1);
      if (second_tick) nt++;
    end
    chk("tick_count", 32'(nt), 60);
    hms("run240", 0, 1, 0);

    mode = 2'b01;
    cyc(1);
    hour_set = 1'b1;
    cyc(92);
    hour_set = 1'b0;
    minute_set = 1'b1;
    cyc(232);
    minute_set = 1'b0;
    hms("preload", 23, 59, 0);

    mode = 2'b00;
    cyc(1);
    cyc(236);
    hms("pre_wrap", 23, 59, 59);
    cyc(3);
    chk("day_early", 32'(day_tick), 0);
    cyc(1);
    hms("wrap", 0, 0, 0);
    chk("day_pulse", 32'(day_tick), 1);
    cyc(1);
    chk("day_single", 32'(day_tick), 0);

    mode = 2'b01;
    cyc(1);
    minute_set = 1'b1;
    cyc(236);
    hms("set_0059", 0, 59, 0);
    cyc(248);
    minute_set = 1'b0;
    hms("min_nocarry", 0, 1, 0);

    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    hms("mid_reset", 0, 0, 0);
    chk("mid_reset_tick", 32'(second_tick), 0);
    cyc(1);
    minute_set = 1'b1;
    hour_set = 1'b1;
    cyc(92);
    hms("both23", 23, 23, 0);
    cyc(4);
    minute_set = 1'b0;
    hour_set = 1'b0;
    hms("both24", 0, 24, 0);

    reset = 1'b1;
    mode = 2'b10;
    cyc(1);
    reset = 1'b0;
    minute_set = 1'b1;
    cyc(8);
    minute_set = 1'b0;
    chk("alarm_set_min", 32'(minute_data), ALARM ? 2 : 0);
    chk("seta_sec_runs", 32'(second_data), 2);
    mode = 2'b01;
    cyc(1);
    minute_set = 1'b1;
    cyc(4);
    minute_set = 1'b0;
    mode = 2'b00;
    alarm_on = 1'b1;
    cyc(1);
    cyc(232);
    hms("pre_alarm", 0, 1, 58);
    chk("pre_alarm_act", 32'(alarm_active), 0);
    cyc(8);
    hms("alarm_hit", 0, 2, 0);
    chk("alarm_on_hit", 32'(alarm_active), 32'(ALARM));
    cyc(8);
    chk("alarm_ring2", 32'(alarm_active), 32'(ALARM));
    cyc(4);
    chk("alarm_expire", 32'(alarm_active), 0);

    mode = 2'b01;
    cyc(1);
    minute_set = 1'b1;
    cyc(236);
    minute_set = 1'b0;
    mode = 2'b00;
    cyc(1);
    cyc(232);
    hms("pre_alarm2", 0, 1, 58);
    cyc(8);
    chk("alarm2_hit", 32'(alarm_active), 32'(ALARM));
    cyc(4);
    chk("alarm2_0201", 32'(alarm_active), 32'(ALARM));
    alarm_ack = 1'b1;
    cyc(1);
    alarm_ack = 1'b0;
    chk("alarm_ack", 32'(alarm_active), 0);
    chk("ack_sec", 32'(second_data), 1);

    alarm_on = 1'b0;
    mode = 2'b10;
    cyc(12);
    chk("mode10_sec", 32'(second_data), 4);
    chk("mode10_act", 32'(alarm_active), 0);
    mode = 2'b00;
    cyc(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
